imem_fetch_unit: RTL and testbench
==================================

Name: imem_fetch_unit

Overview:
- Parametrised, byte-addressed RISC-V instruction memory with a registered, handshaked fetch port and a word-wide program-load port.
- Sits between the PC/IF stage and the IF/ID pipeline register; replaces the combinational asynchronous-read memory.
- Adds one-cycle synchronous read, back-pressure, flush, and alignment/range fault reporting.

Parameters:
- ADDR_W, 64, width of fetch and load addresses (PC width)
- DEPTH_BYTES, 256, storage size in bytes; must be a multiple of 4
- NOP_INSTR, 32'h00000013, word returned on fault or after reset (addi x0,x0,0)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- req_valid  in  1  fetch request present
- req_ready  out  1  unit can accept a request this cycle
- req_addr  in  ADDR_W  byte address of the instruction (PC)
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes the response this cycle
- rsp_instr  out  32  fetched instruction, little-endian assembled
- rsp_addr  out  ADDR_W  address that produced rsp_instr
- rsp_fault  out  1  request was misaligned or out of range
- flush  in  1  discard the held response and any request accepted this cycle
- load_en  in  1  write one word into storage
- load_addr  in  ADDR_W  byte address for the load; must be word-aligned
- load_data  in  32  word to store: byte0 = load_data[7:0] at load_addr

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (reset_n).
- Reset values: rsp_valid=0, rsp_instr=NOP_INSTR, rsp_addr=0, rsp_fault=0, state=EMPTY. Storage is not cleared by reset.
- States and transitions (response register):
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on rsp_ready with no new accept.
  - FULL -> FULL on rsp_ready with a simultaneous accept; the new result replaces the old one with no bubble.
- req_ready = !load_en && (state==EMPTY || rsp_ready).
- Accept = req_valid && req_ready && !flush.
- Latency: an accept in cycle N gives rsp_valid=1 in cycle N+1. Results are returned in order.
- Hold: while rsp_valid && !rsp_ready, rsp_instr, rsp_addr and rsp_fault stay stable.
- Read data: rsp_instr = {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
- Fault condition: a[1:0] != 0, or a > DEPTH_BYTES-4, compared at full ADDR_W width with no truncation or wrap.
  - On fault: rsp_instr=NOP_INSTR, rsp_fault=1, and storage is not read.
- Load port:
  - load_en has priority over fetch and forces req_ready=0.
  - An aligned, in-range load writes 4 bytes at the clock edge.
  - A misaligned or out-of-range load is silently dropped.
  - A fetch accepted on the cycle after a load sees the new data.
- flush: next cycle rsp_valid=0 and state=EMPTY, regardless of rsp_ready or req_valid. flush takes priority over accept.
- Reset mid-operation: the pending response is lost; storage contents are retained.

Optional Feature:
- Macro: IMEM_PERF_CNT_EN.
- With the macro defined:
  - Extra output fetch_cnt [31:0]: increments on every non-faulting accept.
  - Extra output fault_cnt [15:0]: increments on every faulting accept.
  - Both counters saturate at all-ones, reset to 0, and are unaffected by flush.
- Without the macro: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package imem_pkg holds:
  - NOP_INSTR constant
  - response-state enum {EMPTY, FULL}
  - fault-check helper function (alignment and range)
- Sub-module imem_byte_array holds the storage:
  - DEPTH_BYTES x 8 array
  - 32-bit little-endian write port and combinational 32-bit read port
  - imem_fetch_unit registers the read output.

Test Plan:
- Load 0x00e68633 at address 0, then fetch address 0 -> one cycle later rsp_valid=1, rsp_instr=0x00e68633, rsp_addr=0, rsp_fault=0.
- Fetch address 6 -> rsp_instr=0x00000013, rsp_fault=1. Fetch address 256 with DEPTH_BYTES=256 -> rsp_fault=1. Fetch address 252 -> rsp_fault=0.
- Back-to-back fetches of 0, 4, 8 with rsp_ready=1 -> three consecutive valid cycles, in order, no bubbles. Drop rsp_ready for 2 cycles mid-stream -> req_ready=0 and outputs held stable.
- flush asserted together with req_valid for address 4 while FULL -> next cycle rsp_valid=0, and address 4 is never returned.
- load_en asserted with req_valid -> req_ready=0. Load 0x40e68633 to address 4, then fetch 4 on the next cycle -> 0x40e68633. Assert reset_n=0 while FULL -> rsp_valid=0, and the stored word is still readable.
- IMEM_PERF_CNT_EN defined: 5 good fetches plus 2 faulting fetches -> fetch_cnt=5, fault_cnt=2. Force fetch_cnt to 0xFFFFFFFF and fetch again -> value holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants, response-state enum and fault check for the fetch unit
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Width used for address range checks; wide enough that no ADDR_W in use is truncated
  localparam int unsigned CHK_W = 128;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

  function automatic logic addr_fault(input logic [CHK_W-1:0] addr,
                                      input logic [CHK_W-1:0] depth_bytes);
    return (addr[1:0] != 2'b00) || (addr > depth_bytes - CHK_W'(4));
  endfunction

endpackage

// File: rtl/imem_byte_array.sv
// rtl/imem_byte_array.sv - byte storage with 32-bit little-endian write port and combinational read port
module imem_byte_array #(
  parameter int unsigned DEPTH_BYTES = 256,
  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_addr,
  input  logic [31:0]      i_wr_data,
  input  logic [IDX_W-1:0] i_rd_addr,
  output logic [31:0]      o_rd_data
);

  logic [7:0] r_mem [DEPTH_BYTES];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        r_mem[i_wr_addr + IDX_W'(k)] <= i_wr_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int k = 0; k < 4; k++) begin
      o_rd_data[8*k +: 8] = r_mem[i_rd_addr + IDX_W'(k)];
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - registered, handshaked instruction fetch with load port and fault reporting
// Optional perf counters (fetch_cnt, fault_cnt) enabled by IMEM_PERF_CNT_EN.
module imem_fetch_unit #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DEPTH_BYTES = 256,
  parameter logic [31:0] NOP_INSTR   = imem_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_fault,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [15:0]       fault_cnt
`endif
);
  import imem_pkg::*;

  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);

  rsp_state_e        r_state;
  rsp_state_e        w_state_nxt;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_fault;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_req_fault;
  logic              w_load_ok;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [31:0]       w_rd_data;

  assign w_req_fault = addr_fault(CHK_W'(req_addr), CHK_W'(DEPTH_BYTES));
  assign w_load_ok   = load_en && !addr_fault(CHK_W'(load_addr), CHK_W'(DEPTH_BYTES));
  // Faulting requests never index storage, keeping reads inside the array
  assign w_rd_idx    = w_req_fault ? '0 : req_addr[IDX_W-1:0];

  imem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_array (
    .i_clk    (clk),
    .i_wr_en  (w_load_ok),
    .i_wr_addr(load_addr[IDX_W-1:0]),
    .i_wr_data(load_data),
    .i_rd_addr(w_rd_idx),
    .o_rd_data(w_rd_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = !load_en && (r_state == EMPTY || rsp_ready);
    w_accept    = req_valid && w_req_ready && !flush;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else if (w_accept) begin
      w_state_nxt = FULL;
    end else if (r_state == FULL && rsp_ready) begin
      w_state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= EMPTY;
      r_instr <= NOP_INSTR;
      r_addr  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_instr <= w_req_fault ? NOP_INSTR : w_rd_data;
        r_addr  <= req_addr;
        r_fault <= w_req_fault;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = (r_state == FULL);
  assign rsp_instr = r_instr;
  assign rsp_addr  = r_addr;
  assign rsp_fault = r_fault;

`ifdef IMEM_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [15:0] r_fault_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fetch_cnt <= '0;
      r_fault_cnt <= '0;
    end else if (w_accept) begin
      if (w_req_fault) begin
        if (r_fault_cnt != '1) r_fault_cnt <= r_fault_cnt + 16'd1;
      end else begin
        if (r_fetch_cnt != '1) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign fault_cnt = r_fault_cnt;
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb/tb_imem_fetch_unit.sv - self-checking bench for imem_fetch_unit against a behavioural model
module tb_imem_fetch_unit;

  localparam int          AW   = 64;
  localparam int          DB   = 256;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [63:0] LAST = 64'd252;

  logic          clk;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_instr;
  logic [AW-1:0] rsp_addr;
  logic          rsp_fault;
  logic          flush;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
`ifdef IMEM_PERF_CNT_EN
  logic [31:0]   fetch_cnt;
  logic [15:0]   fault_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  imem_fetch_unit #(
    .ADDR_W     (AW),
    .DEPTH_BYTES(DB),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr),
    .rsp_addr (rsp_addr),
    .rsp_fault(rsp_fault),
    .flush    (flush),
    .load_en  (load_en),
    .load_addr(load_addr),
`ifdef IMEM_PERF_CNT_EN
    .fetch_cnt(fetch_cnt),
    .fault_cnt(fault_cnt),
`endif
    .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: byte memory plus the single response slot
  logic [7:0]  m_mem [DB];
  logic        m_valid;
  logic [31:0] m_instr;
  logic [63:0] m_addr;
  logic        m_fault;
  logic [31:0] m_fetch_cnt;
  logic [15:0] m_fault_cnt;

  function automatic logic ref_fault(input logic [63:0] a);
    return (a % 64'd4 != 64'd0) || (a > LAST);
  endfunction

  function automatic logic [31:0] ref_read(input logic [63:0] a);
    int i;
    if (ref_fault(a)) return NOP;
    i = int'(a);
    return {m_mem[i+3], m_mem[i+2], m_mem[i+1], m_mem[i]};
  endfunction

  task automatic idle();
    reset_n   = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
  endtask

  // Advance one clock and update the model from the inputs applied this cycle
  task automatic tick();
    logic rdy;
    logic acc;
    int   i;
    rdy = !load_en && (!m_valid || rsp_ready);
    acc = req_valid && rdy && !flush;
    @(posedge clk);
    if (!reset_n) begin
      m_valid = 1'b0; m_instr = NOP; m_addr = '0; m_fault = 1'b0;
      m_fetch_cnt = '0; m_fault_cnt = '0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_addr  = req_addr;
      m_fault = ref_fault(req_addr);
      m_instr = ref_read(req_addr);
      if (m_fault) begin
        if (m_fault_cnt != 16'hFFFF) m_fault_cnt = m_fault_cnt + 16'd1;
      end else begin
        if (m_fetch_cnt != 32'hFFFFFFFF) m_fetch_cnt = m_fetch_cnt + 32'd1;
      end
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    if (load_en && !ref_fault(load_addr)) begin
      i = int'(load_addr);
      for (int k = 0; k < 4; k++) m_mem[i+k] = load_data[8*k +: 8];
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    n_cmp++; if (rsp_instr !== NOP) begin n_fail++; $display("FAIL reset_instr got=%h exp=%h", rsp_instr, NOP); end
    n_cmp++; if (rsp_addr !== '0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", rsp_addr); end
    n_cmp++; if (rsp_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b exp=0", rsp_fault); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_preload();
    idle();
    for (int w = 0; w < DB/4; w++) begin
      load_en   = 1'b1;
      load_addr = 64'(w * 4);
      load_data = $urandom;
      req_valid = 1'b1;
      req_addr  = 64'(($urandom % 64) * 4);
      #1;
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL preload_ready w=%0d got=%b exp=0", w, req_ready); end
      tick();
    end
    idle();
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL preload_no_rsp got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_basic_fetch();
    idle();
    load_en = 1'b1; load_addr = 64'd0; load_data = 32'h00e68633;
    tick();
    idle();
    req_valid = 1'b1; req_addr = 64'd0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got=%b exp=1", req_ready); end
    tick();
    req_valid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", rsp_valid); end
    n_cmp++; if (rsp_instr !== 32'h00e68633) begin n_fail++; $display("FAIL basic_instr got=%h exp=00e68633", rsp_instr); end
    n_cmp++; if (rsp_addr !== 64'd0) begin n_fail++; $display("FAIL basic_addr got=%h exp=0", rsp_addr); end
    n_cmp++; if (rsp_fault !== 1'b0) begin n_fail++; $display("FAIL basic_fault got=%b exp=0", rsp_fault); end
    rsp_ready = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_faults();
    logic [63:0] addrs [5];
    logic        expf  [5];
    addrs = '{64'd6, 64'd256, 64'd252, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFC};
    expf  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    idle();
    for (int t = 0; t < 5; t++) begin
      req_valid = 1'b1; req_addr = addrs[t]; rsp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL fault_valid a=%h got=%b exp=1", addrs[t], rsp_valid); end
      n_cmp++; if (rsp_fault !== expf[t]) begin n_fail++; $display("FAIL fault_flag a=%h got=%b exp=%b", addrs[t], rsp_fault, expf[t]); end
      n_cmp++; if (rsp_instr !== (expf[t] ? NOP : ref_read(addrs[t]))) begin
        n_fail++; $display("FAIL fault_instr a=%h got=%h exp=%h", addrs[t], rsp_instr, expf[t] ? NOP : ref_read(addrs[t]));
      end
      n_cmp++; if (rsp_addr !== addrs[t]) begin n_fail++; $display("FAIL fault_addr got=%h exp=%h", rsp_addr, addrs[t]); end
      tick();
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    idle();
    rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      req_valid = 1'b1; req_addr = 64'(t * 4);
      tick();
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_addr !== 64'(t * 4)) begin
        n_fail++; $display("FAIL b2b_seq t=%0d got=%b/%h exp=1/%h", t, rsp_valid, rsp_addr, 64'(t * 4));
      end
    end
    held = ref_read(64'd8);
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 64'd12;
    for (int t = 0; t < 2; t++) begin
      #1;
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready t=%0d got=%b exp=0", t, req_ready); end
      tick();
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_addr !== 64'd8 || rsp_instr !== held) begin
        n_fail++; $display("FAIL stall_hold t=%0d got=%b/%h/%h exp=1/8/%h", t, rsp_valid, rsp_addr, rsp_instr, held);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got=%b exp=0", rsp_valid); end
    idle();
  endtask

  task automatic test_flush();
    idle();
    req_valid = 1'b1; req_addr = 64'd0;
    tick();
    flush = 1'b1; req_addr = 64'd4;
    tick();
    idle();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", rsp_valid); end
    rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak t=%0d got=%b/%h exp=0", t, rsp_valid, rsp_addr); end
    end
    idle();
  endtask

  task automatic test_load_then_fetch();
    idle();
    load_en = 1'b1; load_addr = 64'd4; load_data = 32'h40e68633;
    req_valid = 1'b1; req_addr = 64'd4; rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL load_prio_ready got=%b exp=0", req_ready); end
    tick();
    load_en = 1'b0;
    tick();
    req_valid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h40e68633) begin
      n_fail++; $display("FAIL load_fetch got=%b/%h exp=1/40e68633", rsp_valid, rsp_instr);
    end
    load_en = 1'b1; load_addr = 64'd6; load_data = 32'hdeadbeef;
    tick();
    load_addr = 64'd256; load_data = 32'h12345678;
    tick();
    load_en = 1'b0; req_valid = 1'b1; req_addr = 64'd4;
    tick();
    req_addr = 64'd0;
    n_cmp++; if (rsp_instr !== 32'h40e68633) begin n_fail++; $display("FAIL drop_misaligned got=%h exp=40e68633", rsp_instr); end
    tick();
    req_valid = 1'b0;
    n_cmp++; if (rsp_instr !== 32'h00e68633) begin n_fail++; $display("FAIL drop_range got=%h exp=00e68633", rsp_instr); end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    req_valid = 1'b1; req_addr = 64'd4;
    tick();
    req_valid = 1'b0; reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_instr !== NOP) begin
      n_fail++; $display("FAIL midreset got=%b/%h exp=0/%h", rsp_valid, rsp_instr, NOP);
    end
    req_valid = 1'b1; req_addr = 64'd4;
    tick();
    req_valid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h40e68633) begin
      n_fail++; $display("FAIL midreset_keep got=%b/%h exp=1/40e68633", rsp_valid, rsp_instr);
    end
    rsp_ready = 1'b1;
    tick();
    idle();
  endtask

`ifdef IMEM_PERF_CNT_EN
  task automatic test_perf_counters();
    logic [63:0] seq [7];
    seq = '{64'd0, 64'd4, 64'd2, 64'd8, 64'd12, 64'd300, 64'd16};
    idle();
    reset_n = 1'b0;
    tick();
    idle();
    rsp_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      req_valid = 1'b1; req_addr = seq[t];
      tick();
    end
    idle();
    tick();
    n_cmp++; if (fetch_cnt !== 32'd5) begin n_fail++; $display("FAIL perf_fetch got=%0d exp=5", fetch_cnt); end
    n_cmp++; if (fault_cnt !== 16'd2) begin n_fail++; $display("FAIL perf_fault got=%0d exp=2", fault_cnt); end
  endtask
`endif

  task automatic test_random();
    logic exp_rdy;
    int   sel;
    idle();
    for (int c = 0; c < 600; c++) begin
      req_valid = ($urandom % 4) != 0;
      rsp_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 16) == 0;
      load_en   = ($urandom % 10) == 0;
      sel = $urandom % 8;
      if (sel < 6)       req_addr = 64'(($urandom % 64) * 4);
      else if (sel == 6) req_addr = 64'(($urandom % 256) | 1);
      else               req_addr = {32'($urandom), 32'($urandom)} | 64'd256;
      load_addr = (($urandom % 8) == 0) ? 64'(($urandom % 512)) : 64'(($urandom % 64) * 4);
      load_data = $urandom;
      #1;
      exp_rdy = !load_en && (!m_valid || rsp_ready);
      n_cmp++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      n_cmp++; if (rsp_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, rsp_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if (rsp_instr !== m_instr || rsp_addr !== m_addr || rsp_fault !== m_fault) begin
          n_fail++; $display("FAIL rnd_data c=%0d got=%h/%h/%b exp=%h/%h/%b", c, rsp_instr, rsp_addr, rsp_fault, m_instr, m_addr, m_fault);
        end
      end
      tick();
    end
`ifdef IMEM_PERF_CNT_EN
    n_cmp++; if (fetch_cnt !== m_fetch_cnt) begin n_fail++; $display("FAIL rnd_fetch_cnt got=%0d exp=%0d", fetch_cnt, m_fetch_cnt); end
    n_cmp++; if (fault_cnt !== m_fault_cnt) begin n_fail++; $display("FAIL rnd_fault_cnt got=%0d exp=%0d", fault_cnt, m_fault_cnt); end
`endif
    idle();
  endtask

  initial begin
    m_valid = 1'b0; m_instr = NOP; m_addr = '0; m_fault = 1'b0;
    m_fetch_cnt = '0; m_fault_cnt = '0;
    idle();
    test_reset();
    test_preload();
    test_basic_fetch();
    test_faults();
    test_back_to_back();
    test_flush();
    test_load_then_fetch();
    test_reset_mid();
`ifdef IMEM_PERF_CNT_EN
    test_perf_counters();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
